// File: rtl/im_pkg.sv
// rtl/im_pkg.sv - shared types and constants for the instruction memory arbiter
package im_pkg;
  localparam int IM_WORD_W = 32;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } im_arb_state_t;
endpackage

// File: rtl/im_arbiter_if.sv
// rtl/im_arbiter_if.sv - fetch, debug and memory-side signals of the instruction memory arbiter
interface im_arbiter_if
  import im_pkg::*;
#(
  parameter int IDX_W = 7
);
  logic                 fetch_req;
  logic [31:0]          fetch_addr;
  logic                 fetch_gnt;
  logic                 fetch_rvalid;
  logic [IM_WORD_W-1:0] fetch_rdata;

  logic                 dbg_hold;
  logic                 halted;
  logic                 dbg_req;
  logic                 dbg_we;
  logic [31:0]          dbg_addr;
  logic [IM_WORD_W-1:0] dbg_wdata;
  logic                 dbg_gnt;
  logic                 dbg_rvalid;
  logic [IM_WORD_W-1:0] dbg_rdata;
  logic                 dbg_err;

  logic                 mem_en;
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_addr;
  logic [IM_WORD_W-1:0] mem_wdata;
  logic [IM_WORD_W-1:0] mem_rdata;

  // Requesters and the memory array
  modport master (
    output fetch_req, fetch_addr, dbg_hold, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, halted, dbg_gnt, dbg_rvalid, dbg_rdata,
           dbg_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  // The arbiter
  modport slave (
    input  fetch_req, fetch_addr, dbg_hold, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, halted, dbg_gnt, dbg_rvalid, dbg_rdata,
           dbg_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/im_arbiter.sv
// rtl/im_arbiter.sv - shares the single-port instruction memory between fetch and a debug loader
module im_arbiter
  import im_pkg::*;
#(
  parameter int IDX_W    = 7,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  im_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  im_arb_state_t    state_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             fetch_rv_q;
  logic             dbg_rv_q;
  logic             dbg_err_q;
  logic             dbg_rd_q;

  logic             wait_max;
  logic             dbg_aligned;
  logic             fetch_gnt;
  logic             dbg_gnt;
  logic             unused_addr_bits;

  assign wait_max    = (wait_cnt_q == CNT_W'(MAX_WAIT));
  assign dbg_aligned = (bus.dbg_addr[1:0] == 2'b00);

  // dbg_hold blocks new fetch grants in every state, so DRAIN/HALTED with hold
  // released behave exactly like RUN within that same cycle.
  assign fetch_gnt = bus.fetch_req && !bus.dbg_hold && !(bus.dbg_req && wait_max);
  assign dbg_gnt   = bus.dbg_req && !fetch_gnt;

  assign bus.fetch_gnt = fetch_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.halted    = bus.dbg_hold &&
                         ((state_q == HALTED) || ((state_q == DRAIN) && !fetch_rv_q));

  assign bus.mem_en    = fetch_gnt || (dbg_gnt && dbg_aligned);
  assign bus.mem_we    = dbg_gnt && dbg_aligned && bus.dbg_we;
  assign bus.mem_addr  = dbg_gnt ? bus.dbg_addr[IDX_W+1:2] : bus.fetch_addr[IDX_W+1:2];
  assign bus.mem_wdata = bus.mem_we ? bus.dbg_wdata : '0;

  assign bus.fetch_rvalid = fetch_rv_q;
  assign bus.fetch_rdata  = fetch_rv_q ? bus.mem_rdata : '0;
  assign bus.dbg_rvalid   = dbg_rv_q;
  assign bus.dbg_err      = dbg_err_q;
  assign bus.dbg_rdata    = dbg_rd_q ? bus.mem_rdata : '0;

  // Upper address bits alias by design; fetch is always word-wide.
  assign unused_addr_bits = ^{bus.fetch_addr[31:IDX_W+2], bus.fetch_addr[1:0],
                              bus.dbg_addr[31:IDX_W+2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      fetch_rv_q <= 1'b0;
      dbg_rv_q   <= 1'b0;
      dbg_err_q  <= 1'b0;
      dbg_rd_q   <= 1'b0;
    end else begin
      fetch_rv_q <= fetch_gnt;
      dbg_rv_q   <= dbg_gnt;
      dbg_err_q  <= dbg_gnt && !dbg_aligned;
      dbg_rd_q   <= dbg_gnt && dbg_aligned && !bus.dbg_we;

      if (dbg_gnt) begin
        wait_cnt_q <= '0;
      end else if (bus.dbg_req && fetch_gnt && !wait_max) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end

      unique case (state_q)
        RUN: begin
          if (bus.dbg_hold) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!bus.dbg_hold)   state_q <= RUN;
          else if (!fetch_rv_q) state_q <= HALTED;
        end
        HALTED: begin
          if (!bus.dbg_hold) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end
endmodule
